// File: rtl/render_sequencer.sv
`timescale 1ns/1ps
// render_sequencer: alternates a painter phase and a screen-flash phase
// over one shared frame-store port, counting completed frames.
//
// Ports:
//   Clck, Reset        clock, asynchronous active-low reset
//   working            level request to keep rendering frames
//   paint_start/done   painter start pulse out, finish pulse in
//   flash_start/done   flasher start pulse out, finish pulse in
//   paint_addr/color/we painter write request
//   flash_addr         flasher read address
//   mem_addr/data/wren shared memory port, owned by the active phase
//   busy               a PAINT or FLASH phase is in progress
//   frame_count        completed frames, wraps at 256
//   err_timeout        sticky phase-watchdog error
//
// Build option: define RENDER_SEQ_WATCHDOG_EN to add a per-phase
// watchdog (TIMEOUT_CYCLES) with an ABORT state. Without it the FSM
// waits indefinitely for done pulses and err_timeout is tied low.

module render_sequencer #(
   parameter int ADDR_BITS      = 11,
   parameter int COLOR_BITS     = 3,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  Clck,
   input  logic                  Reset,
   input  logic                  working,
   output logic                  paint_start,
   input  logic                  paint_done,
   output logic                  flash_start,
   input  logic                  flash_done,
   input  logic [ADDR_BITS-1:0]  paint_addr,
   input  logic [COLOR_BITS-1:0] paint_color,
   input  logic                  paint_we,
   input  logic [ADDR_BITS-1:0]  flash_addr,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [COLOR_BITS-1:0] mem_data,
   output logic                  mem_wren,
   output logic                  busy,
   output logic [7:0]            frame_count,
   output logic                  err_timeout
);

`ifdef RENDER_SEQ_WATCHDOG_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PAINT = 2'd1,
      S_FLASH = 2'd2,
      S_ABORT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PAINT = 2'd1,
      S_FLASH = 2'd2
   } state_t;
`endif

   state_t     state_q;
   logic       paint_start_q;
   logic       flash_start_q;
   logic [7:0] frame_q;

`ifdef RENDER_SEQ_WATCHDOG_EN
   localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

   logic [15:0] wdog_q;
   logic [15:0] wdog_d;
   logic        wdog_hit;
   logic        err_q;

   // The count after this cycle; the phase has lasted wdog_d cycles.
   assign wdog_d   = wdog_q + 16'd1;
   assign wdog_hit = (wdog_d == TimeoutLim);
`else
   logic [15:0] unused_timeout;
   assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

   // Start pulses are registered on phase entry, so each is high for
   // exactly the first cycle of its phase. A done pulse in that same
   // cycle is honoured, giving one-cycle phases.
   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         state_q       <= S_IDLE;
         paint_start_q <= 1'b0;
         flash_start_q <= 1'b0;
         frame_q       <= '0;
`ifdef RENDER_SEQ_WATCHDOG_EN
         wdog_q        <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         paint_start_q <= 1'b0;
         flash_start_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (working) begin
                  state_q       <= S_PAINT;
                  paint_start_q <= 1'b1;
`ifdef RENDER_SEQ_WATCHDOG_EN
                  wdog_q        <= '0;
`endif
               end
            end
            S_PAINT: begin
               if (paint_done) begin
                  state_q       <= S_FLASH;
                  flash_start_q <= 1'b1;
`ifdef RENDER_SEQ_WATCHDOG_EN
                  wdog_q        <= '0;
               end else if (wdog_hit) begin
                  state_q <= S_ABORT;
                  err_q   <= 1'b1;
                  wdog_q  <= wdog_d;
               end else begin
                  wdog_q  <= wdog_d;
`endif
               end
            end
            S_FLASH: begin
               if (flash_done) begin
                  frame_q <= frame_q + 8'd1;
`ifdef RENDER_SEQ_WATCHDOG_EN
                  wdog_q  <= '0;
`endif
                  // working is only sampled at frame boundaries, so
                  // dropping it mid-frame lets the frame finish.
                  if (working) begin
                     state_q       <= S_PAINT;
                     paint_start_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
`ifdef RENDER_SEQ_WATCHDOG_EN
               end else if (wdog_hit) begin
                  state_q <= S_ABORT;
                  err_q   <= 1'b1;
                  wdog_q  <= wdog_d;
               end else begin
                  wdog_q  <= wdog_d;
`endif
               end
            end
`ifdef RENDER_SEQ_WATCHDOG_EN
            S_ABORT: begin
               state_q <= S_IDLE;
               wdog_q  <= '0;
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Port ownership follows the state register only, so a reset
   // removes the painter's write enable without waiting for a clock.
   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
      unique case (1'b1)
         (state_q == S_PAINT): begin
            mem_addr = paint_addr;
            mem_data = paint_color;
            mem_wren = paint_we;
         end
         (state_q == S_FLASH): begin
            mem_addr = flash_addr;
         end
         default: begin
         end
      endcase
   end

   // ABORT presents IDLE-like outputs, so busy covers the two
   // working phases only.
   assign busy        = (state_q == S_PAINT) ||
                        (state_q == S_FLASH);
   assign paint_start = paint_start_q;
   assign flash_start = flash_start_q;
   assign frame_count = frame_q;

`ifdef RENDER_SEQ_WATCHDOG_EN
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_render_sequencer.sv
`timescale 1ns/1ps
// tb_render_sequencer: scenario tasks plus randomized traffic,
// checked against a frame-level reference model.

module tb_render_sequencer;

`ifdef RENDER_SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
   localparam int TO = 16;
`else
   localparam bit WD = 1'b0;
   localparam int TO = 65535;
`endif

   localparam int P_IDLE  = 0;
   localparam int P_PAINT = 1;
   localparam int P_FLASH = 2;
   localparam int P_ABORT = 3;

   logic        Clck = 1'b0;
   logic        Reset = 1'b1;
   logic        working = 1'b0;
   logic        paint_done = 1'b0;
   logic        flash_done = 1'b0;
   logic [10:0] paint_addr = '0;
   logic [2:0]  paint_color = '0;
   logic        paint_we = 1'b0;
   logic [10:0] flash_addr = '0;
   logic        paint_start;
   logic        flash_start;
   logic [10:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_wren;
   logic        busy;
   logic [7:0]  frame_count;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   // Reference model: which phase, whether this is its first cycle,
   // how long it has lasted, frames done, error seen.
   int m_phase;
   bit m_entry;
   int m_age;
   int m_frames;
   bit m_err;

   logic [26:0] act;
   assign act = {busy, paint_start, flash_start, err_timeout,
                 frame_count, mem_wren, mem_data, mem_addr};

   render_sequencer #(
      .ADDR_BITS(11),
      .COLOR_BITS(3),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clck(Clck),
      .Reset(Reset),
      .working(working),
      .paint_start(paint_start),
      .paint_done(paint_done),
      .flash_start(flash_start),
      .flash_done(flash_done),
      .paint_addr(paint_addr),
      .paint_color(paint_color),
      .paint_we(paint_we),
      .flash_addr(flash_addr),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_wren(mem_wren),
      .busy(busy),
      .frame_count(frame_count),
      .err_timeout(err_timeout)
   );

   always #5 Clck = ~Clck;

   initial begin
      #2000000;
      $display("FAIL global_timeout: sim still running");
      $fatal(1, "timeout");
   end

   function automatic void model_reset();
      m_phase  = P_IDLE;
      m_entry  = 1'b0;
      m_age    = 0;
      m_frames = 0;
      m_err    = 1'b0;
   endfunction

   // One rising edge worth of frame-level behaviour.
   function automatic void model_step();
      m_entry = 1'b0;
      case (m_phase)
         P_IDLE: begin
            if (working) begin
               m_phase = P_PAINT;
               m_entry = 1'b1;
               m_age   = 0;
            end
         end
         P_PAINT, P_FLASH: begin
            if (m_phase == P_PAINT && paint_done) begin
               m_phase = P_FLASH;
               m_entry = 1'b1;
               m_age   = 0;
            end else if (m_phase == P_FLASH && flash_done) begin
               m_frames = (m_frames + 1) % 256;
               m_age    = 0;
               m_phase  = working ? P_PAINT : P_IDLE;
               m_entry  = working;
            end else begin
               m_age = m_age + 1;
               if (WD && m_age == TO) begin
                  m_phase = P_ABORT;
                  m_err   = 1'b1;
               end
            end
         end
         default: m_phase = P_IDLE;
      endcase
   endfunction

   function automatic logic [26:0] exp_vec();
      logic [14:0] mem;
      logic        b;
      logic        ps;
      logic        fs;
      mem = '0;
      if (m_phase == P_PAINT)
         mem = {paint_we, paint_color, paint_addr};
      else if (m_phase == P_FLASH)
         mem = {4'b0000, flash_addr};
      b  = (m_phase == P_PAINT) || (m_phase == P_FLASH);
      ps = (m_phase == P_PAINT) && m_entry;
      fs = (m_phase == P_FLASH) && m_entry;
      return {b, ps, fs, m_err, 8'(m_frames), mem};
   endfunction

   // Advance one clock; model follows the inputs held across the edge.
   task automatic next_edge();
      if (!Reset) model_reset();
      else model_step();
      @(posedge Clck);
      #1;
   endtask

   task automatic clear_inputs();
      working     = 1'b0;
      paint_done  = 1'b0;
      flash_done  = 1'b0;
      paint_we    = 1'b0;
      paint_addr  = '0;
      paint_color = '0;
      flash_addr  = '0;
   endtask

   task automatic apply_reset();
      Reset = 1'b0;
      model_reset();
      clear_inputs();
      @(posedge Clck);
      #2;
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      Reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (act !== 27'd0) begin
         errors++;
         $display("FAIL reset_state: got %h want 0", act);
      end
      working = 1'b1;
      repeat (2) begin
         @(posedge Clck);
         #1;
         checks++;
         if (busy !== 1'b0 || paint_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy %b ps %b want 0 0",
                     busy, paint_start);
         end
      end
      apply_reset();
   endtask

   task automatic test_frame();
      apply_reset();
      working = 1'b1;
      @(negedge Clck);
      checks++;
      if (act !== exp_vec()) begin
         errors++;
         $display("FAIL frame_idle: got %h want %h", act, exp_vec());
      end
      next_edge();
      for (int c = 0; c <= 14; c++) begin
         paint_done = (c == 5);
         flash_done = (c == 13);
         @(negedge Clck);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL frame c%0d: got %h want %h",
                     c, act, exp_vec());
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy c%0d: got %b want 1", c, busy);
         end
         if (c == 6) begin
            checks++;
            if (flash_start !== 1'b1) begin
               errors++;
               $display("FAIL frame_fstart: got %b want 1",
                        flash_start);
            end
         end
         if (c == 14) begin
            checks++;
            if (paint_start !== 1'b1 || frame_count !== 8'd1) begin
               errors++;
               $display("FAIL frame_next: ps %b fc %0d want 1 1",
                        paint_start, frame_count);
            end
         end
         next_edge();
      end
      clear_inputs();
   endtask

   task automatic test_arbitration();
      apply_reset();
      working     = 1'b1;
      paint_we    = 1'b1;
      paint_addr  = 11'h123;
      paint_color = 3'b101;
      @(negedge Clck);
      checks++;
      if (mem_wren !== 1'b0) begin
         errors++;
         $display("FAIL arb_idle_we: got %b want 0", mem_wren);
      end
      next_edge();
      working = 1'b0;
      @(negedge Clck);
      checks++;
      if (mem_addr !== 11'h123 || mem_data !== 3'd5 ||
          mem_wren !== 1'b1) begin
         errors++;
         $display("FAIL arb_paint: got %h/%0d/%b want 123/5/1",
                  mem_addr, mem_data, mem_wren);
      end
      paint_done = 1'b1;
      next_edge();
      paint_done = 1'b0;
      flash_addr = 11'h045;
      @(negedge Clck);
      checks++;
      if (mem_addr !== 11'h045 || mem_data !== 3'd0 ||
          mem_wren !== 1'b0) begin
         errors++;
         $display("FAIL arb_flash: got %h/%0d/%b want 045/0/0",
                  mem_addr, mem_data, mem_wren);
      end
      flash_done = 1'b1;
      next_edge();
      flash_done = 1'b0;
      @(negedge Clck);
      checks++;
      if (act !== exp_vec() || busy !== 1'b0 || mem_wren !== 1'b0) begin
         errors++;
         $display("FAIL arb_done: got %h want %h", act, exp_vec());
      end
      next_edge();
      clear_inputs();
   endtask

   task automatic test_single_request();
      int nps;
      int nfs;
      nps = 0;
      nfs = 0;
      apply_reset();
      working = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 1) working = 1'b0;
         paint_done = (c == 4);
         flash_done = (c == 8);
         @(negedge Clck);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL single c%0d: got %h want %h",
                     c, act, exp_vec());
         end
         nps += int'(paint_start);
         nfs += int'(flash_start);
         next_edge();
      end
      @(negedge Clck);
      checks++;
      if (nps != 1 || nfs != 1 || busy !== 1'b0 ||
          frame_count !== 8'd1) begin
         errors++;
         $display("FAIL single_end: ps %0d fs %0d busy %b fc %0d want 1 1 0 1",
                  nps, nfs, busy, frame_count);
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      apply_reset();
      working    = 1'b1;
      paint_we   = 1'b1;
      paint_addr = 11'h2aa;
      for (int c = 0; c < 5; c++) begin
         paint_done = (c == 1);
         flash_done = (c == 2);
         @(negedge Clck);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL areset_pre c%0d: got %h want %h",
                     c, act, exp_vec());
         end
         if (c == 4) begin
            checks++;
            if (mem_wren !== 1'b1 || frame_count !== 8'd1) begin
               errors++;
               $display("FAIL areset_setup: we %b fc %0d want 1 1",
                        mem_wren, frame_count);
            end
         end
         next_edge();
      end
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (act !== 27'd0) begin
         errors++;
         $display("FAIL areset_now: got %h want 0", act);
      end
      @(posedge Clck);
      #2;
      Reset = 1'b1;
      @(negedge Clck);
      checks++;
      if (paint_start !== 1'b0 || act !== exp_vec()) begin
         errors++;
         $display("FAIL areset_rel0: got %h want %h", act, exp_vec());
      end
      next_edge();
      @(negedge Clck);
      checks++;
      if (paint_start !== 1'b1 || act !== exp_vec()) begin
         errors++;
         $display("FAIL areset_rel1: ps %b want 1", paint_start);
      end
      next_edge();
      clear_inputs();
   endtask

   task automatic test_wrap();
      apply_reset();
      working    = 1'b1;
      paint_done = 1'b1;
      flash_done = 1'b1;
      @(negedge Clck);
      next_edge();
      for (int f = 0; f < 256; f++) begin
         for (int h = 0; h < 2; h++) begin
            @(negedge Clck);
            checks++;
            if (act !== exp_vec()) begin
               errors++;
               $display("FAIL wrap f%0d h%0d: got %h want %h",
                        f, h, act, exp_vec());
            end
            next_edge();
         end
      end
      @(negedge Clck);
      checks++;
      if (frame_count !== 8'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wrap_end: fc %0d busy %b want 0 1",
                  frame_count, busy);
      end
      paint_done = 1'b0;
      paint_we   = 1'b1;
      paint_addr = 11'h3c1;
      for (int c = 0; c < 3; c++) begin
         next_edge();
         @(negedge Clck);
         checks++;
         if (frame_count !== 8'd0 || mem_addr !== 11'h3c1 ||
             flash_start !== 1'b0 || act !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_stray_fdone c%0d: got %h want %h",
                     c, act, exp_vec());
         end
      end
      next_edge();
      clear_inputs();
   endtask

`ifdef RENDER_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      apply_reset();
      working = 1'b1;
      @(negedge Clck);
      next_edge();
      working = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge Clck);
         checks++;
         if (err_timeout !== 1'b0 || busy !== 1'b1 ||
             act !== exp_vec()) begin
            errors++;
            $display("FAIL wd_paint k%0d: got %h want %h",
                     k, act, exp_vec());
         end
         next_edge();
      end
      @(negedge Clck);
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 ||
          mem_wren !== 1'b0 || frame_count !== 8'd0) begin
         errors++;
         $display("FAIL wd_abort: err %b busy %b fc %0d want 1 0 0",
                  err_timeout, busy, frame_count);
      end
      next_edge();
      @(negedge Clck);
      checks++;
      if (err_timeout !== 1'b1 || act !== exp_vec()) begin
         errors++;
         $display("FAIL wd_idle: got %h want %h", act, exp_vec());
      end
      next_edge();
      clear_inputs();
   endtask
`else
   task automatic test_no_watchdog();
      apply_reset();
      working = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge Clck);
         next_edge();
      end
      @(negedge Clck);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1 ||
          act !== exp_vec()) begin
         errors++;
         $display("FAIL no_wd: got %h want %h", act, exp_vec());
      end
      clear_inputs();
   endtask
`endif

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) working = ~working;
         paint_done  = ($urandom_range(0, 3) == 0);
         flash_done  = ($urandom_range(0, 3) == 0);
         paint_addr  = 11'($urandom);
         paint_color = 3'($urandom);
         paint_we    = 1'($urandom);
         flash_addr  = 11'($urandom);
         @(negedge Clck);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL random i%0d: got %h want %h",
                     i, act, exp_vec());
         end
         next_edge();
      end
      clear_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame();
      test_arbitration();
      test_single_request();
      test_async_reset();
      test_wrap();
`ifdef RENDER_SEQ_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
